// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: PWM tone gated by continuous, intermittent or burst cadence.
// Ports: clk, rst_n (sync low), alarm_in, mode, tone/cadence/burst config -> pwm_out, active, done.
module alarm_tone_gen #(
  parameter int CNT_W = 16,
  parameter int CAD_W = 24,
  parameter int BST_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alarm_in,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] tone_period,
  input  logic [CNT_W-1:0] tone_duty,
  input  logic [CAD_W-1:0] on_time,
  input  logic [CAD_W-1:0] off_time,
  input  logic [BST_W-1:0] burst_len,
  output logic             pwm_out,
  output logic             active,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    HOLD
  } state_t;

  localparam logic [1:0] M_CONT  = 2'b00;
  localparam logic [1:0] M_BURST = 2'b10;
  localparam logic [1:0] M_DIS   = 2'b11;

  state_t state, state_nxt;
  logic   done_nxt;

  logic [1:0]       sh_mode;
  logic [CNT_W-1:0] sh_period;
  logic [CNT_W-1:0] sh_duty;
  logic [CAD_W-1:0] sh_on;
  logic [CAD_W-1:0] sh_off;
  logic [BST_W-1:0] sh_burst;

  logic [CNT_W-1:0] tone_cnt;
  logic [CAD_W-1:0] cad_cnt;
  logic [BST_W-1:0] beep_cnt;

  logic             start;
  logic             on_end;
  logic             off_end;
  logic [BST_W-1:0] burst_tgt;
  logic [BST_W-1:0] beep_inc;

  assign start     = alarm_in && (mode != M_DIS);
  assign on_end    = (cad_cnt == sh_on);
  assign off_end   = (cad_cnt == sh_off);
  // A burst length of zero still produces one beep.
  assign burst_tgt = (sh_burst == '0) ? BST_W'(1) : sh_burst;
  assign beep_inc  = beep_cnt + 1'b1;
  assign active    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ON;
      end
      ON: begin
        // Abort takes priority over end of window / end of burst.
        if (!alarm_in) begin
          state_nxt = IDLE;
        end else if (sh_mode != M_CONT && on_end) begin
          if (sh_mode == M_BURST && beep_inc == burst_tgt) begin
            state_nxt = HOLD;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = OFF;
          end
        end
      end
      OFF: begin
        if (!alarm_in)    state_nxt = IDLE;
        else if (off_end) state_nxt = ON;
      end
      HOLD: begin
        if (!alarm_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      pwm_out   <= 1'b0;
      sh_mode   <= '0;
      sh_period <= '0;
      sh_duty   <= '0;
      sh_on     <= '0;
      sh_off    <= '0;
      sh_burst  <= '0;
      tone_cnt  <= '0;
      cad_cnt   <= '0;
      beep_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      done    <= done_nxt;
      pwm_out <= (state == ON) && (tone_cnt < sh_duty);
      if (state == IDLE) begin
        if (start) begin
          sh_mode   <= mode;
          sh_period <= tone_period;
          sh_duty   <= tone_duty;
          sh_on     <= on_time;
          sh_off    <= off_time;
          sh_burst  <= burst_len;
        end
        tone_cnt <= '0;
        cad_cnt  <= '0;
        beep_cnt <= '0;
      end else begin
        // Tone phase restarts on every entry into ON.
        if (state == ON && state_nxt == ON)
          tone_cnt <= (tone_cnt == sh_period) ? '0 : tone_cnt + 1'b1;
        else
          tone_cnt <= '0;
        if (state_nxt != state)
          cad_cnt <= '0;
        else
          cad_cnt <= cad_cnt + 1'b1;
        if (state == ON && on_end && sh_mode == M_BURST && alarm_in)
          beep_cnt <= beep_inc;
      end
    end
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed bench for alarm_tone_gen.
// Expected waveforms are derived from cycle index arithmetic per scenario.
module tb_alarm_tone_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alarm_in;
  logic [1:0]  mode;
  logic [15:0] tone_period;
  logic [15:0] tone_duty;
  logic [23:0] on_time;
  logic [23:0] off_time;
  logic [7:0]  burst_len;
  logic        pwm_out;
  logic        active;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alarm_tone_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .alarm_in(alarm_in),
    .mode(mode),
    .tone_period(tone_period),
    .tone_duty(tone_duty),
    .on_time(on_time),
    .off_time(off_time),
    .burst_len(burst_len),
    .pwm_out(pwm_out),
    .active(active),
    .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    alarm_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic cfg(input logic [1:0] m, input int per, input int dty,
                     input int ont, input int offt, input int bl);
    mode        = m;
    tone_period = 16'(per);
    tone_duty   = 16'(dty);
    on_time     = 24'(ont);
    off_time    = 24'(offt);
    burst_len   = 8'(bl);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg(2'b00, 3, 2, 0, 0, 0);
    alarm_in = 1'b1;
    tick();
    checks++;
    if (pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_pwm got=%b exp=0", pwm_out);
    end
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL reset_active got=%b exp=0", active);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    alarm_in = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_continuous();
    logic e;
    cfg(2'b00, 9, 5, 0, 0, 0);
    alarm_in = 1'b1;
    tick();
    checks++;
    if (active !== 1'b1 || pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL cont_start act=%b pwm=%b exp act=1 pwm=0", active, pwm_out);
    end
    for (int k = 1; k <= 25; k++) begin
      tick();
      e = ((k - 1) % 10) < 5;
      checks++;
      if (pwm_out !== e || done !== 1'b0) begin
        failures++;
        $display("FAIL cont_pwm k=%0d pwm=%b done=%b exp pwm=%b done=0",
                 k, pwm_out, done, e);
      end
    end
    go_idle();
  endtask

  task automatic test_intermittent();
    logic e;
    int p;
    cfg(2'b01, 3, 2, 15, 7, 0);
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 48; k++) begin
      tick();
      p = (k - 1) % 24;
      e = (p < 16) && ((p % 4) < 2);
      checks++;
      if (pwm_out !== e || active !== 1'b1) begin
        failures++;
        $display("FAIL inter_pwm k=%0d pwm=%b act=%b exp pwm=%b act=1",
                 k, pwm_out, active, e);
      end
    end
    go_idle();
  endtask

  task automatic test_burst();
    logic e;
    logic ed;
    int p;
    int pulses;
    pulses = 0;
    cfg(2'b10, 3, 2, 7, 3, 3);
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 40; k++) begin
      tick();
      p = (k - 1) % 12;
      e = (k - 1 < 32) && (p < 8) && ((p % 4) < 2);
      ed = (k == 32);
      if (done === 1'b1) pulses++;
      checks++;
      if (pwm_out !== e || done !== ed || active !== 1'b1) begin
        failures++;
        $display("FAIL burst k=%0d pwm=%b done=%b act=%b exp pwm=%b done=%b act=1",
                 k, pwm_out, done, active, e, ed);
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL burst_pulses got=%0d exp=1", pulses);
    end
    alarm_in = 1'b0;
    tick();
    checks++;
    if (active !== 1'b0 || pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL burst_release act=%b pwm=%b exp 0 0", active, pwm_out);
    end
    tick();
  endtask

  task automatic test_abort();
    logic e;
    cfg(2'b01, 3, 2, 15, 7, 0);
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = ((k - 1) % 4) < 2;
      checks++;
      if (pwm_out !== e) begin
        failures++;
        $display("FAIL abort_pre k=%0d pwm=%b exp=%b", k, pwm_out, e);
      end
    end
    alarm_in = 1'b0;
    tick();
    checks++;
    if (active !== 1'b0 || pwm_out !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle act=%b pwm=%b done=%b exp 0 1 0",
               active, pwm_out, done);
    end
    tick();
    checks++;
    if (pwm_out !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_pwm pwm=%b done=%b exp 0 0", pwm_out, done);
    end
  endtask

  task automatic test_shadow();
    logic e;
    cfg(2'b00, 3, 2, 0, 0, 0);
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) cfg(2'b11, 9, 0, 0, 0, 0);
      e = ((k - 1) % 4) < 2;
      checks++;
      if (pwm_out !== e || active !== 1'b1) begin
        failures++;
        $display("FAIL shadow k=%0d pwm=%b act=%b exp pwm=%b act=1",
                 k, pwm_out, active, e);
      end
    end
    go_idle();
    mode = 2'b00;
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (pwm_out !== 1'b0 || active !== 1'b1) begin
        failures++;
        $display("FAIL duty0 k=%0d pwm=%b act=%b exp pwm=0 act=1",
                 k, pwm_out, active);
      end
    end
    go_idle();
  endtask

  task automatic test_duty_over();
    cfg(2'b00, 3, 7, 0, 0, 0);
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (pwm_out !== 1'b1) begin
        failures++;
        $display("FAIL duty_over k=%0d pwm=%b exp=1", k, pwm_out);
      end
    end
    go_idle();
    checks++;
    if (pwm_out !== 1'b0) begin
      failures++;
      $display("FAIL duty_over_idle pwm=%b exp=0", pwm_out);
    end
  endtask

  task automatic test_disabled();
    cfg(2'b11, 3, 2, 0, 0, 0);
    alarm_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (active !== 1'b0 || pwm_out !== 1'b0) begin
        failures++;
        $display("FAIL disabled k=%0d act=%b pwm=%b exp 0 0",
                 k, active, pwm_out);
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    cfg(2'b10, 3, 2, 7, 3, 3);
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) tick();
    rst_n = 1'b0;
    alarm_in = 1'b0;
    tick();
    checks++;
    if (pwm_out !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid pwm=%b act=%b done=%b exp 0 0 0",
               pwm_out, active, done);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold act=%b exp=0", active);
    end
    alarm_in = 1'b1;
    tick();
    checks++;
    if (active !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_restart act=%b exp=1", active);
    end
    go_idle();
  endtask

  task automatic test_burst_zero();
    logic e;
    logic ed;
    cfg(2'b10, 0, 1, 3, 1, 0);
    alarm_in = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k <= 4);
      ed = (k == 4);
      checks++;
      if (pwm_out !== e || done !== ed || active !== 1'b1) begin
        failures++;
        $display("FAIL burst0 k=%0d pwm=%b done=%b act=%b exp pwm=%b done=%b act=1",
                 k, pwm_out, done, active, e, ed);
      end
    end
    go_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    alarm_in = 1'b0;
    cfg(2'b00, 0, 0, 0, 0, 0);
    test_reset();
    test_continuous();
    test_intermittent();
    test_burst();
    test_abort();
    test_shadow();
    test_duty_over();
    test_disabled();
    test_reset_mid();
    test_burst_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
